// File: rtl/dpram_be_init.sv
// Single-clock true dual-port RAM with per-byte write enables, selectable
// read-during-write behaviour, optional output register and post-reset clear.
module dpram_be_init #(
  parameter int unsigned ADDR_WIDTH = 11,
  parameter int unsigned DATA_WIDTH = 8,
  parameter bit          RDW_MODE   = 1'b0,
  parameter bit          OUT_REG    = 1'b0,
  parameter bit          INIT_CLEAR = 1'b1,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic [ADDR_WIDTH-1:0]   address_a,
  input  logic [DATA_WIDTH-1:0]   data_a,
  input  logic                    wren_a,
  input  logic [DATA_WIDTH/8-1:0] byteena_a,
  output logic [DATA_WIDTH-1:0]   q_a,
  input  logic [ADDR_WIDTH-1:0]   address_b,
  input  logic [DATA_WIDTH-1:0]   data_b,
  input  logic                    wren_b,
  input  logic [DATA_WIDTH/8-1:0] byteena_b,
  output logic [DATA_WIDTH-1:0]   q_b,
  output logic                    busy,
  output logic                    collision
);

  localparam int unsigned NBYTES = DATA_WIDTH / 8;
  localparam int unsigned DEPTH  = 2 ** ADDR_WIDTH;

  typedef enum logic {ST_INIT, ST_READY} state_t;

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   init_cnt;
  logic                    ready;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];
  logic [DATA_WIDTH-1:0]   rd_a, rd_b;
  logic [DATA_WIDTH-1:0]   q1_a, q1_b;

  assign ready = (state == ST_READY);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= INIT_CLEAR ? ST_INIT : ST_READY;
      init_cnt <= '0;
      busy     <= INIT_CLEAR;
    end else if (state == ST_INIT) begin
      init_cnt <= init_cnt + 1'b1;
      if (init_cnt == '1) begin
        state <= ST_READY;
        busy  <= 1'b0;
      end
    end
  end

  // Port A's byte lanes are assigned after port B's, so A wins on overlap.
  always_ff @(posedge clk) begin
    if (state == ST_INIT) begin
      mem[init_cnt] <= INIT_VALUE;
    end else begin
      for (int unsigned i = 0; i < NBYTES; i++) begin
        if (wren_b && byteena_b[i]) mem[address_b][8*i +: 8] <= data_b[8*i +: 8];
        if (wren_a && byteena_a[i]) mem[address_a][8*i +: 8] <= data_a[8*i +: 8];
      end
    end
  end

  // Merged view of each port's own write; the other port always sees old data.
  always_comb begin
    rd_a = mem[address_a];
    rd_b = mem[address_b];
    if (RDW_MODE) begin
      for (int unsigned i = 0; i < NBYTES; i++) begin
        if (wren_a && byteena_a[i]) rd_a[8*i +: 8] = data_a[8*i +: 8];
        if (wren_b && byteena_b[i]) rd_b[8*i +: 8] = data_b[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      q1_a      <= '0;
      q1_b      <= '0;
      collision <= 1'b0;
    end else if (!ready) begin
      q1_a      <= '0;
      q1_b      <= '0;
      collision <= 1'b0;
    end else begin
      q1_a      <= rd_a;
      q1_b      <= rd_b;
      collision <= wren_a && wren_b && (address_a == address_b) &&
                   (|(byteena_a & byteena_b));
    end
  end

  generate
    if (OUT_REG) begin : g_out_reg
      logic [DATA_WIDTH-1:0] q2_a, q2_b;
      always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
          q2_a <= '0;
          q2_b <= '0;
        end else if (!ready) begin
          q2_a <= '0;
          q2_b <= '0;
        end else begin
          q2_a <= q1_a;
          q2_b <= q1_b;
        end
      end
      assign q_a = q2_a;
      assign q_b = q2_b;
    end else begin : g_no_out_reg
      assign q_a = q1_a;
      assign q_b = q1_b;
    end
  endgenerate

endmodule

// File: tb/tb_dpram_be_init.sv
// Directed bench for dpram_be_init: an 8-bit old-data/latency-1 instance and
// a 16-bit new-data/latency-2 instance sharing clock and reset.
module tb_dpram_be_init;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  logic [3:0]  aa8 = '0, ab8 = '0;
  logic [7:0]  da8 = '0, db8 = '0, qa8, qb8;
  logic        wa8 = 1'b0, wb8 = 1'b0, busy8, col8;
  logic [0:0]  ba8 = '0, bb8 = '0;

  logic [3:0]  aa16 = '0, ab16 = '0;
  logic [15:0] da16 = '0, db16 = '0, qa16, qb16;
  logic        wa16 = 1'b0, wb16 = 1'b0, busy16, col16;
  logic [1:0]  ba16 = '0, bb16 = '0;

  int checks = 0;
  int failures = 0;

  dpram_be_init #(
    .ADDR_WIDTH(4), .DATA_WIDTH(8), .RDW_MODE(1'b0), .OUT_REG(1'b0),
    .INIT_CLEAR(1'b1), .INIT_VALUE(8'hA5)
  ) u8 (
    .clk(clk), .resetn(resetn),
    .address_a(aa8), .data_a(da8), .wren_a(wa8), .byteena_a(ba8), .q_a(qa8),
    .address_b(ab8), .data_b(db8), .wren_b(wb8), .byteena_b(bb8), .q_b(qb8),
    .busy(busy8), .collision(col8)
  );

  dpram_be_init #(
    .ADDR_WIDTH(4), .DATA_WIDTH(16), .RDW_MODE(1'b1), .OUT_REG(1'b1),
    .INIT_CLEAR(1'b1), .INIT_VALUE(16'h5A5A)
  ) u16 (
    .clk(clk), .resetn(resetn),
    .address_a(aa16), .data_a(da16), .wren_a(wa16), .byteena_a(ba16), .q_a(qa16),
    .address_b(ab16), .data_b(db16), .wren_b(wb16), .byteena_b(bb16), .q_b(qb16),
    .busy(busy16), .collision(col16)
  );

  typedef struct {
    logic [3:0] aa; logic [7:0] da; logic wa; logic ba;
    logic [3:0] ab; logic [7:0] db; logic wb; logic bb;
    logic [7:0] qa; logic [7:0] qb; logic col;
  } vec_t;

  vec_t vt [14];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic c16(input logic [3:0] aa, input logic [15:0] da, input logic wa,
                     input logic [1:0] ba, input logic [3:0] ab, input logic [15:0] db,
                     input logic wb, input logic [1:0] bb);
    aa16 = aa; da16 = da; wa16 = wa; ba16 = ba;
    ab16 = ab; db16 = db; wb16 = wb; bb16 = bb;
    @(posedge clk); #1;
  endtask

  initial begin
    //        aa    da     wa ba  ab    db     wb bb  qa     qb     col
    vt[0]  = '{4'd5, 8'h11, 1, 1, 4'd0, 8'h00, 0, 0, 8'hA5, 8'hA5, 0};
    vt[1]  = '{4'd5, 8'h22, 1, 1, 4'd5, 8'h00, 0, 0, 8'h11, 8'h11, 0};
    vt[2]  = '{4'd5, 8'h00, 0, 0, 4'd5, 8'h00, 0, 0, 8'h22, 8'h22, 0};
    vt[3]  = '{4'd5, 8'h77, 1, 0, 4'd5, 8'h00, 0, 0, 8'h22, 8'h22, 0};
    vt[4]  = '{4'd5, 8'h00, 0, 0, 4'd6, 8'h33, 1, 1, 8'h22, 8'hA5, 0};
    vt[5]  = '{4'd7, 8'h44, 1, 1, 4'd7, 8'h55, 1, 1, 8'hA5, 8'hA5, 1};
    vt[6]  = '{4'd7, 8'h00, 0, 0, 4'd7, 8'h00, 0, 0, 8'h44, 8'h44, 0};
    vt[7]  = '{4'd8, 8'h66, 1, 1, 4'd8, 8'h77, 1, 0, 8'hA5, 8'hA5, 0};
    vt[8]  = '{4'd8, 8'h00, 0, 0, 4'd8, 8'h00, 0, 0, 8'h66, 8'h66, 0};
    vt[9]  = '{4'd9, 8'h00, 0, 0, 4'd9, 8'h99, 1, 1, 8'hA5, 8'hA5, 0};
    vt[10] = '{4'd9, 8'h00, 0, 0, 4'd9, 8'h00, 0, 0, 8'h99, 8'h99, 0};
    vt[11] = '{4'hF, 8'hC3, 1, 1, 4'd0, 8'h3C, 1, 1, 8'hA5, 8'hA5, 0};
    vt[12] = '{4'hF, 8'h00, 0, 0, 4'd0, 8'h00, 0, 0, 8'hC3, 8'h3C, 0};
    vt[13] = '{4'd6, 8'h00, 0, 0, 4'd2, 8'h00, 0, 0, 8'h33, 8'hA5, 0};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_q_a8", 16'(qa8), 16'h0);
    chk("rst_q_b8", 16'(qb8), 16'h0);
    chk("rst_busy8", 16'(busy8), 16'h1);
    chk("rst_col8", 16'(col8), 16'h0);
    chk("rst_q_a16", qa16, 16'h0);
    chk("rst_busy16", 16'(busy16), 16'h1);

    // First clear, interrupted by reset at cnt=6
    @(negedge clk) resetn = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      @(posedge clk); #1;
      chk($sformatf("init1_busy8_%0d", c), 16'(busy8), 16'h1);
    end
    resetn = 1'b0;
    #1;
    chk("midrst_q_a8", 16'(qa8), 16'h0);
    chk("midrst_busy8", 16'(busy8), 16'h1);
    chk("midrst_busy16", 16'(busy16), 16'h1);
    chk("midrst_q_a16", qa16, 16'h0);

    // Full clear reruns; writes to address 0 late in the clear must be dropped
    @(negedge clk) resetn = 1'b1;
    for (int c = 1; c <= 16; c++) begin
      if (c >= 6) begin
        aa8 = 4'd0;  da8 = 8'hFF;    wa8 = 1'b1;  ba8 = 1'b1;
        aa16 = 4'd0; da16 = 16'hFFFF; wa16 = 1'b1; ba16 = 2'b11;
      end
      @(posedge clk); #1;
      chk($sformatf("init2_busy8_%0d", c), 16'(busy8), (c < 16) ? 16'h1 : 16'h0);
      chk($sformatf("init2_busy16_%0d", c), 16'(busy16), (c < 16) ? 16'h1 : 16'h0);
      if (c < 16) begin
        chk($sformatf("init2_q_a8_%0d", c), 16'(qa8), 16'h0);
        chk($sformatf("init2_q_a16_%0d", c), qa16, 16'h0);
      end
    end
    wa8 = 1'b0; ba8 = '0; da8 = '0;
    wa16 = 1'b0; ba16 = '0; da16 = '0;

    // Every word holds the fill value
    for (int a = 0; a < 16; a++) begin
      aa8 = 4'(a);  ab8 = 4'(15 - a);
      aa16 = 4'(a); ab16 = 4'(15 - a);
      repeat (2) @(posedge clk);
      #1;
      chk($sformatf("fill_q_a8_%0d", a), 16'(qa8), 16'h00A5);
      chk($sformatf("fill_q_b8_%0d", a), 16'(qb8), 16'h00A5);
      chk($sformatf("fill_q_a16_%0d", a), qa16, 16'h5A5A);
      chk($sformatf("fill_q_b16_%0d", a), qb16, 16'h5A5A);
    end
    aa16 = '0; ab16 = '0;

    // Table: 8-bit instance, old-data RDW, one-cycle latency
    for (int i = 0; i < 14; i++) begin
      aa8 = vt[i].aa; da8 = vt[i].da; wa8 = vt[i].wa; ba8 = vt[i].ba;
      ab8 = vt[i].ab; db8 = vt[i].db; wb8 = vt[i].wb; bb8 = vt[i].bb;
      @(posedge clk); #1;
      chk($sformatf("vec%0d_q_a", i), 16'(qa8), 16'(vt[i].qa));
      chk($sformatf("vec%0d_q_b", i), 16'(qb8), 16'(vt[i].qb));
      chk($sformatf("vec%0d_col", i), 16'(col8), 16'(vt[i].col));
    end
    wa8 = 1'b0; wb8 = 1'b0;

    // Byte-enable partial write and no-op write
    c16(4'd3, 16'h1234, 1, 2'b11, 4'd0, 16'h0, 0, 2'b00);
    c16(4'd3, 16'hABCD, 1, 2'b01, 4'd0, 16'h0, 0, 2'b00);
    c16(4'd3, 16'hABCD, 1, 2'b00, 4'd0, 16'h0, 0, 2'b00);
    c16(4'd3, 16'h0,    0, 2'b00, 4'd0, 16'h0, 0, 2'b00);
    chk("be01_q_a16", qa16, 16'h12CD);
    c16(4'd3, 16'h0,    0, 2'b00, 4'd0, 16'h0, 0, 2'b00);
    chk("be00_q_a16", qa16, 16'h12CD);

    // New-data same-port RDW, old data cross-port
    c16(4'd5, 16'h1111, 1, 2'b11, 4'd0, 16'h0, 0, 2'b00);
    c16(4'd5, 16'h2222, 1, 2'b11, 4'd5, 16'h0, 0, 2'b00);
    c16(4'd5, 16'h0,    0, 2'b00, 4'd5, 16'h0, 0, 2'b00);
    chk("rdw_q_a16", qa16, 16'h2222);
    chk("rdw_cross_q_b16", qb16, 16'h1111);
    c16(4'd5, 16'h0033, 1, 2'b01, 4'd5, 16'h0, 0, 2'b00);
    c16(4'd5, 16'h0,    0, 2'b00, 4'd5, 16'h0, 0, 2'b00);
    chk("rdw_merge_q_a16", qa16, 16'h2233);
    c16(4'd5, 16'h0,    0, 2'b00, 4'd5, 16'h0, 0, 2'b00);
    chk("rdw_merge_q_b16", qb16, 16'h2233);

    // Write-write collisions on address 7
    c16(4'd7, 16'hAAAA, 1, 2'b11, 4'd7, 16'hBBBB, 1, 2'b10);
    chk("coll_overlap", 16'(col16), 16'h1);
    c16(4'd7, 16'h0, 0, 2'b00, 4'd7, 16'h0, 0, 2'b00);
    chk("coll_pulse_end", 16'(col16), 16'h0);
    c16(4'd7, 16'h0, 0, 2'b00, 4'd7, 16'h0, 0, 2'b00);
    chk("coll_a_wins_q_a", qa16, 16'hAAAA);
    chk("coll_a_wins_q_b", qb16, 16'hAAAA);
    c16(4'd7, 16'hAAAA, 1, 2'b01, 4'd7, 16'hBBBB, 1, 2'b10);
    chk("coll_disjoint", 16'(col16), 16'h0);
    c16(4'd7, 16'h0, 0, 2'b00, 4'd7, 16'h0, 0, 2'b00);
    c16(4'd7, 16'h0, 0, 2'b00, 4'd7, 16'h0, 0, 2'b00);
    chk("coll_disjoint_q_a", qa16, 16'hBBAA);

    // Two-cycle read latency with the output register
    c16(4'd0, 16'h0, 0, 2'b00, 4'd9, 16'h3C3C, 1, 2'b11);
    c16(4'd9, 16'h0, 0, 2'b00, 4'd0, 16'h0, 0, 2'b00);
    chk("lat_cycle1_q_a16", qa16, 16'h5A5A);
    c16(4'd9, 16'h0, 0, 2'b00, 4'd0, 16'h0, 0, 2'b00);
    chk("lat_cycle2_q_a16", qa16, 16'h3C3C);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
